program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Upstream boot stage for the 16-bit processor. Takes a byte stream (valid/ready) from a host link,
//  assembles 16-bit instruction words high byte first, and writes them into instruction memory via
//  its en_write/address/data_in port. Holds the core in reset while loading, then releases it with start high.
//  Stream format: 16-bit word count N, then N instruction words (plus checksum word if enabled).
// PARAMETERS
//  ADDR_WIDTH  10    IM address width
//  MAX_WORDS   1024  largest accepted N; N > MAX_WORDS -> ERROR
//  RESET_HOLD  2     cycles cpu_reset stays high after last IM write
// PORTS
//  clk           in   1           system clock, rising edge
//  reset         in   1           asynchronous, active-low reset
//  load_go       in   1           level/pulse; starts a load from IDLE or RUN
//  byte_valid    in   1           host byte available
//  byte_data     in   8           host byte
//  byte_ready    out  1           loader accepts byte this cycle
//  im_en_write   out  1           IM write strobe, one cycle per word
//  im_address    out  ADDR_WIDTH  IM write address
//  im_data       out  16          IM write data
//  cpu_reset     out  1           active-high reset to the processor core
//  cpu_start     out  1           processor start level
//  busy          out  1           high in every state except IDLE, RUN, ERROR
//  error         out  1           sticky until next load_go or reset
//  words_loaded  out  ADDR_WIDTH+1  words written in current/last load
// BEHAVIOUR
//  Reset (reset==0, async): state IDLE; byte_ready=0, im_en_write=0, im_address=0, im_data=0,
//   cpu_reset=1, cpu_start=0, busy=0, error=0, words_loaded=0. Reset mid-load aborts it; no further IM writes.
//  Byte accept: byte_valid && byte_ready on rising clk. byte_ready=1 only in HDR_HI/HDR_LO/DATA_HI/DATA_LO.
//  States:
//   IDLE:    load_go -> HDR_HI; cpu_reset=1, error cleared, words_loaded cleared, index=0.
//   HDR_HI:  accept -> count[15:8]; -> HDR_LO.
//   HDR_LO:  accept -> count[7:0]; count==0 -> RELEASE; count>MAX_WORDS -> ERROR; else DATA_HI.
//   DATA_HI: accept -> word[15:8]; -> DATA_LO.
//   DATA_LO: accept -> word[7:0]; -> WRITE.
//   WRITE:   one cycle: im_en_write=1, im_address=index, im_data=word; index++, words_loaded++;
//            index==count-1 (last) -> CHECK_HI if CHECKSUM_EN, else RELEASE; otherwise -> DATA_HI.
//   RELEASE: cpu_reset=1 for RESET_HOLD cycles (counter), then -> RUN.
//   RUN:     cpu_reset=0, cpu_start=1. load_go -> IDLE-equivalent entry: cpu_reset=1, cpu_start=0, -> HDR_HI.
//   ERROR:   cpu_reset=1, cpu_start=0, error=1; load_go -> HDR_HI (error cleared).
//  Latency: first IM write 1 cycle after the accepting edge of its low byte; min 3 cycles per word.
//  im_address/im_data hold last written values outside WRITE; im_en_write never high outside WRITE.
//  Index wraps never: count<=MAX_WORDS guarantees index < 2**ADDR_WIDTH.
//  load_go during HDR..RELEASE ignored. byte_valid outside accept states ignored (byte not consumed).
// CONFIGURATION
//  PROGRAM_LOADER_CHECKSUM_EN defined: stream carries one trailing word = XOR of all N data words.
//   States CHECK_HI/CHECK_LO accept it; match -> RELEASE, mismatch -> ERROR (core never released).
//   Words already written stay in IM. For N==0 the checksum word is still expected and must be 0x0000.
//  Not defined: no checksum states; after last WRITE -> RELEASE directly.
// TESTING
//  1. reset low mid-cycle -> all outputs at reset values immediately; cpu_reset=1.
//  2. load_go, bytes 00 02 40 04 70 00 -> writes IM[0]=0x4004, IM[1]=0x7000; RESET_HOLD=2 cycles
//     later cpu_reset=0, cpu_start=1, words_loaded=2.
//  3. Same stream with byte_valid toggling every other cycle -> identical writes, no duplicated bytes.
//  4. Header 04 01 (N=1025) -> ERROR, error=1, no im_en_write; load_go -> busy=1, error=0.
//  5. In RUN, load_go + header 00 00 -> cpu_reset re-asserted, cpu_start=0, no writes, RUN again.
//  6. CHECKSUM_EN: words 0x4004,0x7000 then 0x3004 -> RUN; then 0x3005 -> ERROR, cpu_reset stays 1.

Source files
------------

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : program_loader
//  Description : Boot-stage loader for the 16-bit core. Receives a byte
//                stream (valid/ready), assembles 16-bit words high byte
//                first and writes them to instruction memory. The core is
//                held in reset while loading and released afterwards.
//                Stream: 16-bit word count N, then N words.
//                Optional feature macro PROGRAM_LOADER_CHECKSUM_EN: a
//                trailing XOR checksum word follows the N data words.
//  Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_WORDS  = 1024,
    parameter int RESET_HOLD = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_go,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  im_en_write,
    output logic [ADDR_WIDTH-1:0] im_address,
    output logic [15:0]           im_data,
    output logic                  cpu_reset,
    output logic                  cpu_start,
    output logic                  busy,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    // Hold counter counts 0 .. RESET_HOLD-1 while in S_RELEASE
    localparam int c_hold_w = (RESET_HOLD > 2) ? $clog2(RESET_HOLD) : 1;
    localparam logic [c_hold_w-1:0] c_hold_last =
        c_hold_w'((RESET_HOLD > 0) ? RESET_HOLD - 1 : 0);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR_HI,
        S_HDR_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CHECK_HI,
        S_CHECK_LO,
`endif
        S_RELEASE,
        S_RUN,
        S_ERROR
    } state_t;

    state_t                r_state;
    logic [15:0]           r_count;
    logic [7:0]            r_word_hi;
    logic [ADDR_WIDTH-1:0] r_index;
    logic [c_hold_w-1:0]   r_hold;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [15:0]           r_xsum;
`endif

    logic        w_accept;
    logic [15:0] w_hdr_count;
    logic        w_last;

    // Ready and busy are pure decodes of the registered state
    assign byte_ready = (r_state == S_HDR_HI)  || (r_state == S_HDR_LO)  ||
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        (r_state == S_CHECK_HI) || (r_state == S_CHECK_LO) ||
`endif
                        (r_state == S_DATA_HI) || (r_state == S_DATA_LO);
    assign busy        = (r_state != S_IDLE) && (r_state != S_RUN) &&
                         (r_state != S_ERROR);
    assign w_accept    = byte_valid && byte_ready;
    assign w_hdr_count = {r_count[15:8], byte_data};
    assign w_last      = (32'(r_index) + 32'd1) == 32'(r_count);

    // Loader state machine with registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_word_hi    <= '0;
            r_index      <= '0;
            r_hold       <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            r_xsum       <= '0;
`endif
            im_en_write  <= 1'b0;
            im_address   <= '0;
            im_data      <= '0;
            cpu_reset    <= 1'b1;
            cpu_start    <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            im_en_write <= 1'b0;
            case (r_state)
                S_IDLE, S_RUN, S_ERROR: begin
                    // A new load always restarts from a clean slate
                    if (load_go) begin
                        r_state      <= S_HDR_HI;
                        cpu_reset    <= 1'b1;
                        cpu_start    <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= '0;
                        r_index      <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        r_xsum       <= '0;
`endif
                    end
                end
                S_HDR_HI: begin
                    if (w_accept) begin
                        r_count[15:8] <= byte_data;
                        r_state       <= S_HDR_LO;
                    end
                end
                S_HDR_LO: begin
                    if (w_accept) begin
                        r_count[7:0] <= byte_data;
                        r_hold       <= '0;
                        if (w_hdr_count == 16'd0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                            r_state <= S_CHECK_HI;
`else
                            r_state <= S_RELEASE;
`endif
                        end else if (32'(w_hdr_count) > 32'(MAX_WORDS)) begin
                            r_state <= S_ERROR;
                            error   <= 1'b1;
                        end else begin
                            r_state <= S_DATA_HI;
                        end
                    end
                end
                S_DATA_HI: begin
                    if (w_accept) begin
                        r_word_hi <= byte_data;
                        r_state   <= S_DATA_LO;
                    end
                end
                S_DATA_LO: begin
                    // Strobe is raised here so it is high during S_WRITE
                    if (w_accept) begin
                        im_en_write <= 1'b1;
                        im_address  <= r_index;
                        im_data     <= {r_word_hi, byte_data};
                        r_state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_index      <= r_index + 1'b1;
                    words_loaded <= words_loaded + 1'b1;
                    r_hold       <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    r_xsum       <= r_xsum ^ im_data;
                    r_state      <= w_last ? S_CHECK_HI : S_DATA_HI;
`else
                    r_state      <= w_last ? S_RELEASE : S_DATA_HI;
`endif
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                S_CHECK_HI: begin
                    if (w_accept) begin
                        r_word_hi <= byte_data;
                        r_state   <= S_CHECK_LO;
                    end
                end
                S_CHECK_LO: begin
                    if (w_accept) begin
                        if ({r_word_hi, byte_data} == r_xsum) begin
                            r_state <= S_RELEASE;
                        end else begin
                            r_state <= S_ERROR;
                            error   <= 1'b1;
                        end
                    end
                end
`endif
                S_RELEASE: begin
                    if (r_hold == c_hold_last) begin
                        r_state   <= S_RUN;
                        cpu_reset <= 1'b0;
                        cpu_start <= 1'b1;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_program_loader
//  Description : Self-checking bench for program_loader. Random streams are
//                driven; a reference model queues expected IM writes, a
//                monitor pops and compares them as the DUT writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    localparam int ADDR_WIDTH = 10;
    localparam int MAX_WORDS  = 1024;
    localparam int RESET_HOLD = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  load_go;
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  im_en_write;
    logic [ADDR_WIDTH-1:0] im_address;
    logic [15:0]           im_data;
    logic                  cpu_reset;
    logic                  cpu_start;
    logic                  busy;
    logic                  error;
    logic [ADDR_WIDTH:0]   words_loaded;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] a;
        logic [15:0]           d;
    } wr_t;

    wr_t         exp_q[$];
    logic [15:0] wq[$];
    wr_t         mon_e;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          last_wr_cyc = 0;

    program_loader #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MAX_WORDS  (MAX_WORDS),
        .RESET_HOLD (RESET_HOLD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load_go      (load_go),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .im_en_write  (im_en_write),
        .im_address   (im_address),
        .im_data      (im_data),
        .cpu_reset    (cpu_reset),
        .cpu_start    (cpu_start),
        .busy         (busy),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every IM write must match the head of the expected queue
    always @(negedge clk) begin
        if (reset === 1'b1 && im_en_write === 1'b1) begin
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%0h:%0h required=none", im_address, im_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("im_address", 32'(im_address), 32'(mon_e.a));
                chk("im_data", 32'(im_data), 32'(mon_e.d));
            end
        end
    end

    // gap: 0 = back-to-back, 1 = idle cycle before every byte, 2 = random idle
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        @(negedge clk);
        if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        t = 0;
        while (byte_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            checks++;
            failures++;
            $display("FAIL byte_timeout actual=ready_low required=ready_high");
        end
        @(posedge clk);
        #1 byte_valid = 1'b0;
    endtask

    task automatic go();
        @(negedge clk);
        load_go = 1'b1;
        @(negedge clk);
        load_go = 1'b0;
        chk("go_busy", 32'(busy), 32'd1);
        chk("go_error", 32'(error), 32'd0);
        chk("go_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("go_cpu_start", 32'(cpu_start), 32'd0);
        chk("go_words_loaded", 32'(words_loaded), 32'd0);
    endtask

    // Reference model: a load of n words from wq, outcome from plain rules
    task automatic run_load(input int n, input bit corrupt, input int gap);
        bit          exp_err;
        logic [15:0] x;
        logic [15:0] nn;
        int          t;
        nn      = n[15:0];
        x       = 16'h0000;
        exp_err = (n > MAX_WORDS);
        if (!exp_err) begin
            for (int i = 0; i < n; i++) begin
                exp_q.push_back('{a: ADDR_WIDTH'(i), d: wq[i]});
                x = x ^ wq[i];
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            if (corrupt) exp_err = 1'b1;
`endif
        end
        go();
        send_byte(nn[15:8], gap);
        send_byte(nn[7:0], gap);
        if (n <= MAX_WORDS) begin
            for (int i = 0; i < n; i++) begin
                send_byte(wq[i][15:8], gap);
                send_byte(wq[i][7:0], gap);
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            x = x ^ {15'd0, corrupt};
            send_byte(x[15:8], gap);
            send_byte(x[7:0], gap);
`endif
        end
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (cpu_start !== 1'b1 && error !== 1'b1 && t < 400);
        if (t >= 400) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=busy required=run_or_error");
        end
        chk("end_error", 32'(error), 32'(exp_err));
        chk("end_cpu_start", 32'(cpu_start), 32'(!exp_err));
        chk("end_cpu_reset", 32'(cpu_reset), 32'(exp_err));
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_words_loaded", 32'(words_loaded), (n > MAX_WORDS) ? 32'd0 : 32'(n));
        chk("end_queue_empty", 32'(exp_q.size()), 32'd0);
`ifndef PROGRAM_LOADER_CHECKSUM_EN
        if (!exp_err && n > 0)
            chk("release_latency", 32'(cyc - last_wr_cyc), 32'(RESET_HOLD + 1));
`endif
        repeat (3) @(negedge clk);
        chk("hold_cpu_reset", 32'(cpu_reset), 32'(exp_err));
        chk("hold_no_write", 32'(im_en_write), 32'd0);
    endtask

    task automatic fill_random(input int n);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back(16'($urandom));
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        load_go    = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        #2 reset = 1'b0;
        #1;
        chk("rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("rst_im_en_write", 32'(im_en_write), 32'd0);
        chk("rst_im_address", 32'(im_address), 32'd0);
        chk("rst_im_data", 32'(im_data), 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_cpu_start", 32'(cpu_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_words_loaded", 32'(words_loaded), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_start", 32'(cpu_start), 32'd0);

        // Two-word program, back-to-back and with byte_valid toggling
        wq = '{16'h4004, 16'h7000};
        run_load(2, 1'b0, 0);
        run_load(2, 1'b0, 1);

        // Oversized header goes to ERROR without writes
        run_load(1025, 1'b0, 0);

        // Reload from ERROR, then an empty program from RUN
        fill_random(3);
        run_load(3, 1'b0, 2);
        run_load(0, 1'b0, 0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        wq = '{16'h4004, 16'h7000};
        run_load(2, 1'b0, 0);
        run_load(2, 1'b1, 0);
`endif

        // Randomized loads
        for (int k = 0; k < 10; k++) begin
            n = $urandom_range(0, 6);
            fill_random(n);
            run_load(n, 1'($urandom_range(0, 1)), 2);
        end

        // Largest accepted program
        fill_random(MAX_WORDS);
        run_load(MAX_WORDS, 1'b0, 0);

        // Reset in the middle of a load after one word was written
        wq = '{16'h1234, 16'hBEEF, 16'h0F0F};
        exp_q.push_back('{a: '0, d: 16'h1234});
        go();
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'hBE, 0);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("mid_rst_im_address", 32'(im_address), 32'd0);
        chk("mid_rst_im_data", 32'(im_data), 32'd0);
        chk("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_byte_ready", 32'(byte_ready), 32'd0);
        chk("mid_rst_words_loaded", 32'(words_loaded), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'hEF;
        repeat (8) @(negedge clk);
        byte_valid = 1'b0;
        chk("abort_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cpu_reset", 32'(cpu_reset), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
